// File: rtl/kbd_ring_writer_if.sv
// Bundles the keyboard byte strobe and the io-port write handshake of kbd_ring_writer.
// master is the writer side; slave is the key source / io arbiter side.
interface kbd_ring_writer_if;
  logic        key_valid;
  logic [7:0]  key_ascii;
  logic        io_gnt;
  logic        io_req;
  logic [15:0] io_addr;
  logic        io_wren;
  logic [7:0]  io_wdata;

  modport master (
    input  key_valid, key_ascii, io_gnt,
    output io_req, io_addr, io_wren, io_wdata
  );

  modport slave (
    output key_valid, key_ascii, io_gnt,
    input  io_req, io_addr, io_wren, io_wdata
  );
endinterface

// File: rtl/kbd_ring_writer.sv
// Buffers decoded keyboard bytes and writes each into a memory ring through the shared io port,
// publishing the updated write pointer after every character.
module kbd_ring_writer #(
  parameter logic [15:0] BUF_BASE   = 16'h0100,
  parameter int          BUF_LEN    = 64,
  parameter logic [15:0] PTR_ADDR   = 16'h0140,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  kbd_ring_writer_if.master           bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);
  localparam int WW    = $clog2(BUF_LEN);
  localparam int FAW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, WR_CHAR, WR_PTR} state_t;

  state_t          state, next_state;
  logic [WW-1:0]   wptr;
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [FAW-1:0]  rd_idx, wr_idx;
  logic            full, push, pop;
  logic            io_req;
  logic [15:0]     io_addr;
  logic [7:0]      io_wdata;

  assign full = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign pop  = (state == WR_CHAR) && bus.io_gnt;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept the byte.
  assign push = bus.key_valid && (!full || pop);

  assign bus.io_req   = io_req;
  assign bus.io_wren  = io_req;
  assign bus.io_addr  = io_addr;
  assign bus.io_wdata = io_wdata;

  always_comb begin
    next_state = state;
    io_req     = 1'b0;
    io_addr    = 16'h0000;
    io_wdata   = 8'h00;
    case (state)
      IDLE: begin
        if (fifo_count != '0) next_state = WR_CHAR;
      end
      WR_CHAR: begin
        io_req   = 1'b1;
        io_addr  = BUF_BASE + 16'(wptr);
        io_wdata = fifo_mem[rd_idx];
        if (bus.io_gnt) next_state = WR_PTR;
      end
      WR_PTR: begin
        io_req   = 1'b1;
        io_addr  = PTR_ADDR;
        io_wdata = 8'(wptr);
        // Occupancy after this edge includes a byte pushed in this very cycle.
        if (bus.io_gnt) next_state = ((fifo_count != '0) || push) ? WR_CHAR : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wptr       <= '0;
      rd_idx     <= '0;
      wr_idx     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      state <= next_state;
      if (pop) begin
        rd_idx <= rd_idx + 1'b1;
        wptr   <= wptr + 1'b1;
      end
      if (push) wr_idx <= wr_idx + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (bus.key_valid && !push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) fifo_mem[wr_idx] <= bus.key_ascii;
  end
endmodule

// File: tb/tb_kbd_ring_writer.sv
// Directed bench for kbd_ring_writer: expected io writes go into a scoreboard queue
// and a negedge monitor compares every committed write against it.
module tb_kbd_ring_writer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] fifo_count;
  logic       overflow;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  kbd_ring_writer_if bus ();

  kbd_ring_writer dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic kv, input logic [7:0] ch, input logic gnt);
    bus.key_valid = kv;
    bus.key_ascii = ch;
    bus.io_gnt    = gnt;
  endtask

  task automatic expectWrite(input logic [15:0] a, input logic [7:0] d, input int c);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic resetDut();
    rst = 1'b1;
    // A key offered during reset must be discarded.
    applyStimulus(1'b1, 8'hEE, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while ((sb.size() != 0 || bus.io_req) && n < 300) begin
      tick();
      n++;
    end
    checkOutput(name, 32'(sb.size() == 0 && !bus.io_req), 32'd1);
  endtask

  // Scoreboard monitor: a write commits in any cycle with io_req and io_gnt both high.
  always @(negedge clk) begin
    if (bus.io_req && bus.io_gnt) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none", bus.io_addr, bus.io_wdata);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("wr_addr", 32'(bus.io_addr), 32'(mon_e.addr));
        checkOutput("wr_data", 32'(bus.io_wdata), 32'(mon_e.data));
        checkOutput("wr_wren", 32'(bus.io_wren), 32'd1);
        if (mon_e.cyc >= 0) checkOutput("wr_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    applyStimulus(1'b0, 8'h00, 1'b0);

    // Reset values
    resetDut();
    checkOutput("rst_io_req", 32'(bus.io_req), 32'd0);
    checkOutput("rst_io_wren", 32'(bus.io_wren), 32'd0);
    checkOutput("rst_io_addr", 32'(bus.io_addr), 32'd0);
    checkOutput("rst_io_wdata", 32'(bus.io_wdata), 32'd0);
    checkOutput("rst_fifo_count", 32'(fifo_count), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    tick();
    checkOutput("rst_key_dropped", 32'(fifo_count), 32'd0);

    // Single key with exact latency
    applyStimulus(1'b1, 8'h41, 1'b1);
    n = cyc;
    expectWrite(16'h0100, 8'h41, n + 2);
    expectWrite(16'h0140, 8'h01, n + 3);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1);
    tick();
    tick();
    tick();
    checkOutput("single_idle_n4", 32'(bus.io_req), 32'd0);
    waitDrain("single_drain");

    // Stall in WR_CHAR
    resetDut();
    applyStimulus(1'b1, 8'h42, 1'b0);
    expectWrite(16'h0100, 8'h42, -1);
    expectWrite(16'h0140, 8'h01, -1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_req", 32'(bus.io_req), 32'd1);
      checkOutput("stall_addr", 32'(bus.io_addr), 32'h0100);
      checkOutput("stall_data", 32'(bus.io_wdata), 32'h42);
      tick();
    end
    bus.io_gnt = 1'b1;
    waitDrain("stall_drain");

    // Overflow: five keys into a four-entry FIFO with no grant
    resetDut();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'(8'h61 + i), 1'b0);
      tick();
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("ovf_count", 32'(fifo_count), 32'd4);
    checkOutput("ovf_flag", 32'(overflow), 32'd1);
    checkOutput("ovf_head", 32'(bus.io_wdata), 32'h61);
    for (int i = 0; i < 4; i++) begin
      expectWrite(16'(16'h0100 + i), 8'(8'h61 + i), -1);
      expectWrite(16'h0140, 8'(i + 1), -1);
    end
    bus.io_gnt = 1'b1;
    waitDrain("ovf_drain");
    checkOutput("ovf_sticky", 32'(overflow), 32'd1);
    checkOutput("ovf_empty", 32'(fifo_count), 32'd0);

    // Full FIFO with simultaneous push and pop
    resetDut();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'(8'h71 + i), 1'b0);
      tick();
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("pp_full", 32'(fifo_count), 32'd4);
    for (int i = 0; i < 5; i++) begin
      expectWrite(16'(16'h0100 + i), 8'(8'h71 + i), -1);
      expectWrite(16'h0140, 8'(i + 1), -1);
    end
    applyStimulus(1'b1, 8'h75, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("pp_count", 32'(fifo_count), 32'd4);
    checkOutput("pp_overflow", 32'(overflow), 32'd0);
    checkOutput("pp_ptr_addr", 32'(bus.io_addr), 32'h0140);
    bus.io_gnt = 1'b1;
    waitDrain("pp_drain");

    // Ring wrap after 64 characters
    resetDut();
    for (int i = 0; i < 65; i++) begin
      applyStimulus(1'b1, 8'(8'h20 + i), 1'b1);
      expectWrite(16'(16'h0100 + (i % 64)), 8'(8'h20 + i), -1);
      expectWrite(16'h0140, 8'((i + 1) % 64), -1);
      tick();
      applyStimulus(1'b0, 8'h00, 1'b1);
      tick();
      tick();
      tick();
      tick();
    end
    waitDrain("wrap_drain");

    // Reset while in WR_PTR
    resetDut();
    applyStimulus(1'b1, 8'h51, 1'b1);
    expectWrite(16'h0100, 8'h51, -1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1);
    tick();
    tick();
    checkOutput("midrst_in_wr_ptr", 32'(bus.io_addr), 32'h0140);
    rst = 1'b1;
    applyStimulus(1'b1, 8'h5A, 1'b0);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("midrst_req", 32'(bus.io_req), 32'd0);
    checkOutput("midrst_count", 32'(fifo_count), 32'd0);
    checkOutput("midrst_sb", 32'(sb.size()), 32'd0);
    applyStimulus(1'b1, 8'h52, 1'b1);
    expectWrite(16'h0100, 8'h52, -1);
    expectWrite(16'h0140, 8'h01, -1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1);
    waitDrain("midrst_drain");

    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/kbd_ring_writer.md
KBD_RING_WRITER -- requirements
Module: kbd_ring_writer

Interface
REQ-001 SHALL have parameter BUF_BASE, default 16'h0100, meaning the io-port byte address of ring buffer entry 0.
REQ-002 SHALL have parameter BUF_LEN, default 64, meaning the ring length in bytes; only powers of two from 2 to 256 are legal.
REQ-003 SHALL have parameter PTR_ADDR, default 16'h0140, meaning the io-port byte address where the write pointer is published.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, meaning the input FIFO entries; only powers of two are legal.
REQ-005 SHALL have port clk, input, 1 bit: the sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port key_valid, input, 1 bit: one-cycle strobe marking a new ASCII byte from the PS/2 decoder.
REQ-008 SHALL have port key_ascii, input, 8 bits: the byte qualified by key_valid.
REQ-009 SHALL have port io_gnt, input, 1 bit: io-port (data memory port B) arbiter grant.
REQ-010 SHALL have port io_req, output, 1 bit: this block requests an io-port write.
REQ-011 SHALL have port io_addr, output, 16 bits: byte address driven to the io port.
REQ-012 SHALL have port io_wren, output, 1 bit: write enable, always equal to io_req.
REQ-013 SHALL have port io_wdata, output, 8 bits: write data.
REQ-014 SHALL have port fifo_count, output, log2(FIFO_DEPTH)+1 bits: current FIFO occupancy.
REQ-015 SHALL have port overflow, output, 1 bit: sticky flag set when a byte is dropped.

Function
REQ-016 SHALL commit a write in exactly the cycle where io_req=1 and io_gnt=1; io_addr, io_wdata and io_req SHALL stay stable until that cycle.
REQ-017 SHALL push key_ascii into the FIFO on any cycle with key_valid=1 and either the FIFO not full or a pop occurring in the same cycle.
REQ-018 SHALL drop the byte and set overflow=1 when key_valid=1, the FIFO is full, and no pop occurs that cycle; overflow SHALL clear only on rst.
REQ-019 SHALL keep an internal write pointer wptr of log2(BUF_LEN) bits, reset to 0.
REQ-020 SHALL implement FSM states IDLE, WR_CHAR and WR_PTR, with reset state IDLE.
REQ-021 In IDLE, SHALL keep io_req=0 and transition to WR_CHAR at the next edge if fifo_count>0.
REQ-022 In WR_CHAR, SHALL drive io_req=1, io_addr=BUF_BASE+wptr and io_wdata=FIFO head.
REQ-023 On a WR_CHAR grant, SHALL pop the FIFO, set wptr to (wptr+1) mod BUF_LEN and go to WR_PTR.
REQ-024 In WR_PTR, SHALL drive io_req=1, io_addr=PTR_ADDR and io_wdata=the already-updated wptr, zero-extended to 8 bits.
REQ-025 On a WR_PTR grant, SHALL go to WR_CHAR if fifo_count>0 after that edge, otherwise to IDLE.
REQ-026 SHALL hold state and outputs in any request state while io_gnt=0, while still accepting pushes.
REQ-027 SHALL wrap wptr from BUF_LEN-1 to 0; the character is written at BUF_BASE+BUF_LEN-1 and the published pointer is 0.
REQ-028 SHALL never check the CPU read pointer; a ring overrun silently overwrites unread bytes.
REQ-029 SHALL give latency, with io_gnt=1 and starting from IDLE with an empty FIFO: key_valid in cycle N produces the character write in cycle N+2, the pointer write in cycle N+3, and IDLE in cycle N+4.
REQ-030 SHALL compute fifo_count exactly under a simultaneous push and pop, leaving it unchanged.

Reset
REQ-031 On rst=1 at an edge, SHALL set state=IDLE, io_req=0, io_wren=0, io_addr=0, io_wdata=0, fifo_count=0, overflow=0 and wptr=0, regardless of any in-flight request.
REQ-032 SHALL discard any key_valid in a cycle where rst=1, and SHALL NOT clear the ring contents in memory.

Verification
REQ-033 Single key: rst released, io_gnt=1, key_valid with 8'h41 in cycle N -> cycle N+2 writes 0x0100<=0x41, cycle N+3 writes 0x0140<=0x01.
REQ-034 Stall: io_gnt=0 for 5 cycles during WR_CHAR -> io_addr=0x0100 and io_wdata held stable, no state change, commit on the first cycle with io_gnt=1.
REQ-035 Overflow: io_gnt=0 and 5 consecutive key_valid pulses -> fifo_count=4, overflow=1, 5th byte lost; then io_gnt=1 -> exactly 4 character writes.
REQ-036 Wrap: 64 keys written -> 64th char at 0x013F, published pointer 0x00; 65th char at 0x0100.
REQ-037 Full with simultaneous push and pop: FIFO full, WR_CHAR granted and key_valid in the same cycle -> byte accepted, fifo_count stays 4, overflow stays 0.
REQ-038 Reset mid-write: rst asserted in WR_PTR -> next cycle io_req=0, fifo_count=0, and the next key is written at 0x0100.
